// File: rtl/instr_fetch_ctrl.sv
// Instruction fetch sequencer: owns the fetch PC, reads the combinational ROM and
// queues {pc, instruction} pairs for decode; handles redirects and halt detection.
module instr_fetch_ctrl #(
  parameter logic [31:0] RESET_PC   = 32'd0,
  parameter int          ROM_BYTES  = 404,
  parameter int          FIFO_DEPTH = 2
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        fetch_en,
  output logic [31:0] rom_address,
  input  logic [31:0] rom_instruction,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_pc,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [31:0] out_instr,
  output logic [31:0] out_pc,
  output logic        halted
);
  localparam int PW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int CW = PW + 1;

  typedef enum logic [1:0] {S_FETCH, S_FULL, S_HALT} state_t;

  state_t          r_state, w_next_state;
  logic [31:0]     r_fpc;
  logic [31:0]     r_mem_pc [FIFO_DEPTH];
  logic [31:0]     r_mem_in [FIFO_DEPTH];
  logic [PW-1:0]   r_wr, r_rd;
  logic [CW-1:0]   r_count, w_count_next;
  logic            w_pop, w_room, w_end, w_run, w_push, w_selfloop;

  assign rom_address = r_fpc;
  assign out_valid   = (r_count != '0);
  assign out_instr   = out_valid ? r_mem_in[r_rd] : 32'd0;
  assign out_pc      = out_valid ? r_mem_pc[r_rd] : 32'd0;
  assign halted      = (r_state == S_HALT);

  assign w_pop      = out_valid & out_ready;
  assign w_room     = (r_count < CW'(FIFO_DEPTH)) | w_pop;
  // 33-bit compare so a PC near 2^32 can never wrap past the ROM end
  assign w_end      = ({1'b0, r_fpc} + 33'd4) > 33'(ROM_BYTES);
  assign w_run      = (r_state != S_HALT) & fetch_en & ~redirect_valid;
  assign w_push     = w_run & w_room & ~w_end;
  assign w_selfloop = (rom_instruction[31:26] == 6'b101010) & (rom_instruction[15:0] == 16'hFFFF);
  assign w_count_next = r_count + CW'(w_push) - CW'(w_pop);

  always_comb begin
    w_next_state = r_state;
    if (redirect_valid)
      w_next_state = S_FETCH;
    else if (r_state != S_HALT) begin
      if (w_run & w_end)
        w_next_state = S_HALT;
      else if (w_push & w_selfloop)
        w_next_state = S_HALT;
      else if (w_count_next == CW'(FIFO_DEPTH))
        w_next_state = S_FULL;
      else
        w_next_state = S_FETCH;
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      r_state <= S_FETCH;
      r_fpc   <= RESET_PC;
      r_wr    <= '0;
      r_rd    <= '0;
      r_count <= '0;
    end else if (redirect_valid) begin
      // flush wins over any push/pop requested this cycle
      r_state <= w_next_state;
      r_fpc   <= {redirect_pc[31:2], 2'b00};
      r_wr    <= '0;
      r_rd    <= '0;
      r_count <= '0;
    end else begin
      r_state <= w_next_state;
      r_count <= w_count_next;
      if (w_push) begin
        r_fpc <= r_fpc + 32'd4;
        r_wr  <= r_wr + PW'(1);
      end
      if (w_pop)
        r_rd <= r_rd + PW'(1);
    end
  end

  always_ff @(posedge clock) begin
    if (!reset && !redirect_valid && w_push) begin
      r_mem_pc[r_wr] <= r_fpc;
      r_mem_in[r_wr] <= rom_instruction;
    end
  end
endmodule
